// File: rtl/period_counter_pkg.sv
// Shared types and constants for the period counter.
// State encoding, counter ceiling and default prescale.
package period_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE,
    DONE
  } state_e;

  localparam logic [15:0] MAX_COUNT = 16'hFFFF;
  localparam int unsigned DEFAULT_PRESCALE = 100;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
// The edge pulse lags sig_in by SYNC_STAGES+1 cycles.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_o <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/period_counter.sv
// Measures the sig_in period between two rising edges in prescaled ticks.
// Single-shot or continuous; results saturate at MAX_COUNT.
module period_counter
  import period_counter_pkg::*;
#(
  parameter int unsigned PRESCALE    = DEFAULT_PRESCALE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sig_in,
  input  logic        start,
  input  logic        cont_mode,
  output logic [15:0] period_out,
  output logic        valid,
  output logic        busy,
  output logic        overflow
);

  localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);

  state_e      state_q;
  logic [15:0] psc_q;
  logic [15:0] cnt_q;
  logic [15:0] psc_d;
  logic [15:0] cnt_d;
  logic        edge_s;
  logic        tick;
  logic        sat;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .sig_in (sig_in),
    .edge_o (edge_s)
  );

  // cnt_d already includes the tick of the current cycle,
  // so on a closing edge it equals floor(N / PRESCALE).
  assign tick  = (psc_q == PSC_LAST);
  assign psc_d = tick ? '0 : psc_q + 16'd1;
  assign cnt_d = tick ? cnt_q + 16'd1 : cnt_q;
  assign sat   = tick && (cnt_q == MAX_COUNT - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      psc_q      <= '0;
      cnt_q      <= '0;
      period_out <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start || cont_mode) begin
            state_q <= WAIT_FIRST;
            busy    <= 1'b1;
            psc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        WAIT_FIRST: begin
          psc_q <= psc_d;
          cnt_q <= cnt_d;
          if (edge_s) begin
            state_q <= MEASURE;
            psc_q   <= '0;
            cnt_q   <= '0;
          end else if (sat) begin
            state_q    <= DONE;
            busy       <= 1'b0;
            valid      <= 1'b1;
            period_out <= MAX_COUNT;
            overflow   <= 1'b1;
          end
        end
        MEASURE: begin
          psc_q <= psc_d;
          cnt_q <= cnt_d;
          if (edge_s) begin
            state_q    <= DONE;
            busy       <= 1'b0;
            valid      <= 1'b1;
            period_out <= cnt_d;
            overflow   <= 1'b0;
          end else if (sat) begin
            state_q    <= DONE;
            busy       <= 1'b0;
            valid      <= 1'b1;
            period_out <= MAX_COUNT;
            overflow   <= 1'b1;
          end
        end
        DONE: begin
          if (cont_mode) begin
            state_q <= WAIT_FIRST;
            busy    <= 1'b1;
            psc_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_counter.sv
// Bench for period_counter: table-driven measurements, saturation,
// timeout, continuous mode and mid-measurement reset on parallel instances.
module tb_period_counter;

  localparam int ND = 7;
  localparam int NV = 9;

  logic clk;
  logic rst_n;
  logic [ND-1:0] sig_v;
  logic [ND-1:0] start_v;
  logic [ND-1:0] cont_v;
  logic [ND-1:0] valid_v;
  logic [ND-1:0] busy_v;
  logic [ND-1:0] ovf_v;
  logic [ND-1:0] vprev;
  logic [15:0]   pout [ND];

  typedef struct {
    int          dut;
    logic [15:0] per;
    logic        ovf;
  } exp_t;

  typedef struct {
    int n;
    int e1;
    int e100;
  } vec_t;

  exp_t sb[$];
  vec_t vt[NV];
  int   total;
  int   bad;

  // instances 1 and 5 use PRESCALE=100, the rest PRESCALE=1
  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int unsigned PS = (g == 1 || g == 5) ? 100 : 1;
    period_counter #(
      .PRESCALE   (PS),
      .SYNC_STAGES(2)
    ) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .sig_in    (sig_v[g]),
      .start     (start_v[g]),
      .cont_mode (cont_v[g]),
      .period_out(pout[g]),
      .valid     (valid_v[g]),
      .busy      (busy_v[g]),
      .overflow  (ovf_v[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string nm, int g, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%0d expected=%0d", nm, g, act, exp);
    end
  endtask

  function automatic logic [ND-1:0] msk(int g);
    return ND'(1) << g;
  endfunction

  function automatic int pending(int g);
    int c;
    c = 0;
    foreach (sb[i]) if (sb[i].dut == g) c++;
    return c;
  endfunction

  task automatic sb_push(int g, logic [15:0] p, logic o);
    sb.push_back('{dut: g, per: p, ovf: o});
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sig(logic [ND-1:0] m, logic v);
    sig_v = v ? (sig_v | m) : (sig_v & ~m);
  endtask

  task automatic pulse_start(logic [ND-1:0] m);
    start_v = start_v | m;
    cyc(1);
    start_v = start_v & ~m;
  endtask

  // k rising edges spaced exactly n cycles apart, ending low
  task automatic square(logic [ND-1:0] m, int n, int k);
    for (int i = 0; i < k; i++) begin
      set_sig(m, 1'b1);
      cyc(n / 2);
      set_sig(m, 1'b0);
      cyc(n - n / 2);
    end
  endtask

  task automatic two_edges(int g, int n, logic [15:0] e);
    pulse_start(msk(g));
    cyc(3);
    sb_push(g, e, 1'b0);
    set_sig(msk(g), 1'b1);
    cyc(100);
    set_sig(msk(g), 1'b0);
    cyc(n - 100);
    set_sig(msk(g), 1'b1);
    cyc(20);
    set_sig(msk(g), 1'b0);
    cyc(10);
    check("pending", g, pending(g), 0);
    check("busy_after", g, busy_v[g], 0);
  endtask

  // scoreboard consumer: every valid pulse must match an expected entry
  always @(negedge clk) begin
    for (int g = 0; g < ND; g++) begin
      if (valid_v[g]) begin
        int idx;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].dut == g) idx = i;
        check("valid_width", g, vprev[g], 0);
        if (idx < 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid dut=%0d got=%0d expected=none",
                   g, pout[g]);
        end else begin
          check("period", g, pout[g], sb[idx].per);
          check("overflow", g, ovf_v[g], sb[idx].ovf);
          check("busy_in_done", g, busy_v[g], 0);
          sb.delete(idx);
        end
      end
    end
    vprev = valid_v;
  end

  initial begin
    total   = 0;
    bad     = 0;
    vprev   = '0;
    rst_n   = 1'b0;
    sig_v   = '0;
    start_v = '0;
    cont_v  = '0;

    vt[0] = '{n: 1000, e1: 1000, e100: 10};
    vt[1] = '{n: 500,  e1: 500,  e100: 5};
    vt[2] = '{n: 250,  e1: 250,  e100: 2};
    vt[3] = '{n: 100,  e1: 100,  e100: 1};
    vt[4] = '{n: 99,   e1: 99,   e100: 0};
    vt[5] = '{n: 199,  e1: 199,  e100: 1};
    vt[6] = '{n: 200,  e1: 200,  e100: 2};
    vt[7] = '{n: 37,   e1: 37,   e100: 0};
    vt[8] = '{n: 3,    e1: 3,    e100: 0};

    cyc(3);
    for (int g = 0; g < ND; g++) begin
      check("rst_period", g, pout[g], 0);
      check("rst_valid", g, valid_v[g], 0);
      check("rst_busy", g, busy_v[g], 0);
      check("rst_ovf", g, ovf_v[g], 0);
    end
    rst_n = 1'b1;
    cyc(3);

    fork
      begin : br_table
        square(msk(0), 50, 2);
        cyc(10);
        check("idle_ignores_edges", 0, busy_v[0], 0);
        for (int i = 0; i < NV; i++) begin
          pulse_start(msk(0) | msk(1));
          cyc(3);
          check("armed_busy", 0, busy_v[0], 1);
          check("armed_busy", 1, busy_v[1], 1);
          sb_push(0, 16'(vt[i].e1), 1'b0);
          sb_push(1, 16'(vt[i].e100), 1'b0);
          square(msk(0) | msk(1), vt[i].n, 2);
          cyc(10);
          check("pending", 0, pending(0), 0);
          check("pending", 1, pending(1), 0);
          check("busy_after", 0, busy_v[0], 0);
          check("hold", 0, pout[0], vt[i].e1);
          check("hold", 1, pout[1], vt[i].e100);
        end
      end
      begin : br_timeout
        pulse_start(msk(2));
        cyc(3);
        check("armed_busy", 2, busy_v[2], 1);
        sb_push(2, 16'hFFFF, 1'b1);
        cyc(100);
        pulse_start(msk(2));
        cyc(65400);
        check("timeout_not_early", 2, pending(2), 1);
        cyc(100);
        check("pending", 2, pending(2), 0);
        check("busy_after", 2, busy_v[2], 0);
      end
      begin : br_sat
        pulse_start(msk(3));
        cyc(3);
        sb_push(3, 16'hFFFF, 1'b1);
        set_sig(msk(3), 1'b1);
        cyc(10);
        set_sig(msk(3), 1'b0);
        cyc(65400);
        check("sat_not_early", 3, pending(3), 1);
        cyc(300);
        check("pending", 3, pending(3), 0);
        check("busy_after", 3, busy_v[3], 0);
        check("ovf_hold", 3, ovf_v[3], 1);
      end
      begin : br_edge_at_sat
        two_edges(4, 65535, 16'hFFFF);
      end
      begin : br_below_sat
        two_edges(6, 65534, 16'hFFFE);
      end
      begin : br_cont
        cont_v[5] = 1'b1;
        cyc(3);
        check("cont_armed", 5, busy_v[5], 1);
        sb_push(5, 16'd250, 1'b0);
        sb_push(5, 16'd250, 1'b0);
        square(msk(5), 25000, 2);
        set_sig(msk(5), 1'b1);
        cyc(12500);
        set_sig(msk(5), 1'b0);
        cyc(5000);
        check("cont_rearmed", 5, busy_v[5], 1);
        cont_v[5] = 1'b0;
        cyc(7500);
        set_sig(msk(5), 1'b1);
        cyc(20);
        set_sig(msk(5), 1'b0);
        cyc(20);
        check("pending", 5, pending(5), 0);
        check("busy_after", 5, busy_v[5], 0);
      end
    join

    // reset in the middle of a measurement on instance 0
    pulse_start(msk(0));
    cyc(3);
    set_sig(msk(0), 1'b1);
    cyc(50);
    set_sig(msk(0), 1'b0);
    cyc(200);
    check("measuring_busy", 0, busy_v[0], 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_period", 0, pout[0], 0);
    check("midrst_valid", 0, valid_v[0], 0);
    check("midrst_busy", 0, busy_v[0], 0);
    check("midrst_ovf", 0, ovf_v[0], 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    set_sig(msk(0), 1'b1);
    cyc(50);
    set_sig(msk(0), 1'b0);
    cyc(50);
    check("post_rst_idle", 0, busy_v[0], 0);
    pulse_start(msk(0));
    cyc(3);
    sb_push(0, 16'd500, 1'b0);
    square(msk(0), 500, 2);
    cyc(10);
    check("pending", 0, pending(0), 0);
    check("hold", 0, pout[0], 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_counter.md
PERIOD_COUNTER -- requirements
Module: period_counter

Interface
REQ-001 SHALL have parameter PRESCALE, default 100; clk cycles per count tick (1 us at 100 MHz); legal range 1..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2; synchronizer depth on sig_in; minimum 2.
REQ-003 SHALL have port clk  in  1: the system clock (>=25 MHz); all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port sig_in  in  1: asynchronous signal whose period is measured between rising edges.
REQ-006 SHALL have port start  in  1: one-cycle pulse that arms a single measurement.
REQ-007 SHALL have port cont_mode  in  1: when HI, re-arm automatically after every result.
REQ-008 SHALL have port period_out  out  16: last result in ticks; drives the 16-bit display value input.
REQ-009 SHALL have port valid  out  1: one-cycle pulse when period_out/overflow update.
REQ-010 SHALL have port busy  out  1: HI while armed or measuring.
REQ-011 SHALL have port overflow  out  1: HI if the last result saturated; held with period_out.

Function
REQ-012 SHALL synchronize sig_in through SYNC_STAGES flops, then a rising-edge detect flop; edge pulse lags sig_in by SYNC_STAGES+1 cycles, identical for both edges.
REQ-013 SHALL implement states IDLE, WAIT_FIRST, MEASURE, DONE.
REQ-014 IDLE: start or cont_mode HI -> WAIT_FIRST; sig_in edges ignored.
REQ-015 WAIT_FIRST: edge -> MEASURE, clear tick count and prescaler to 0 in that cycle.
REQ-016 MEASURE: prescaler counts 0..PRESCALE-1; tick when at PRESCALE-1; tick count +1 per tick.
REQ-017 MEASURE: next edge -> DONE, capture period_out = floor(N/PRESCALE), N = clk cycles between the two detected edges.
REQ-018 Tick count SHALL saturate: reaching 0xFFFF without an edge -> DONE, period_out=0xFFFF, overflow=1.
REQ-019 Edge in the same cycle as saturation SHALL win: period_out=0xFFFF, overflow=0.
REQ-020 WAIT_FIRST SHALL time out after 0xFFFF ticks without an edge -> DONE, period_out=0xFFFF, overflow=1.
REQ-021 DONE lasts exactly one cycle; valid=1 in DONE; period_out and overflow change only on the cycle DONE is entered and hold otherwise.
REQ-022 DONE -> WAIT_FIRST if cont_mode HI, else IDLE; in continuous mode the closing edge is not reused as the next first edge.
REQ-023 busy SHALL be HI in WAIT_FIRST and MEASURE, LO in IDLE and DONE.
REQ-024 start while busy SHALL be ignored; clearing cont_mode mid-measurement completes the current measurement, then -> IDLE.

Reset
REQ-025 reset_n LO SHALL immediately force IDLE, period_out=0, valid=0, busy=0, overflow=0, counters and synchronizer flops 0.
REQ-026 Reset mid-measurement SHALL discard partial results; no valid pulse follows reset release without a new start or cont_mode.

Structure
REQ-027 Shared package period_counter_pkg SHALL hold the state encoding, MAX_COUNT=16'hFFFF and default PRESCALE.
REQ-028 Synchronizer plus edge detector SHALL be one sub-module, sync_edge_detect, parameterized by SYNC_STAGES.
REQ-029 period_out SHALL be registered; no combinational path from sig_in to any output.

Verification
REQ-030 PRESCALE=1, single start, sig_in square wave period 1000 clk -> one valid pulse, period_out=1000, overflow=0, busy LO afterwards.
REQ-031 PRESCALE=100, cont_mode=1, period 25000 clk -> valid every other sig_in period, each period_out=250.
REQ-032 PRESCALE=1, start, one edge then sig_in held LO for 70000 clk -> valid, period_out=0xFFFF, overflow=1.
REQ-033 PRESCALE=1, start, sig_in constant LO -> after 65535 ticks valid, period_out=0xFFFF, overflow=1; second start while busy has no effect.
REQ-034 reset_n pulsed LO mid-MEASURE -> all outputs 0 same cycle; no valid until a new start; next measurement of period 500 returns 500.
REQ-035 Edges exactly 65535 ticks apart (PRESCALE=1) -> period_out=0xFFFF, overflow=0.
